uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver. It supports:
- configurable data width, parity and stop bits;
- an input synchroniser and 3-sample majority voting;
- parity, framing and break detection;
- a valid/ready output holding register with overrun reporting.

It sits between the pad-side rx line and any byte consumer, such as a FIFO or register bank.

---
 rtl/uart_rx_cfg.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised rx line, 3-sample majority voting per bit,
// parity/framing/break status and a valid/ready holding register with overrun pulse.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 20,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] d_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int M  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] C_S0   = CW'(M - 1);
    localparam logic [CW-1:0] C_S1   = CW'(M);
    localparam logic [CW-1:0] C_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_DLAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] I_SLAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   perr_f_q, perr_f_d;
    logic                   ferr_f_q, ferr_f_d;
    logic                   zero_q, zero_d;
    logic [DATA_BITS-1:0]   d_q, d_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
    logic                   ovr_q, ovr_d;
    logic                   rxs, maj, dec, last, complete;

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign maj  = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign dec  = (cnt_q == C_DEC);
    assign last = (cnt_q == C_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            sync_q   <= '1;
            cnt_q    <= '0;
            idx_q    <= '0;
            s0_q     <= 1'b1;
            s1_q     <= 1'b1;
            shift_q  <= '0;
            par_q    <= 1'b0;
            perr_f_q <= 1'b0;
            ferr_f_q <= 1'b0;
            zero_q   <= 1'b0;
            d_q      <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_i};
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            perr_f_q <= perr_f_d;
            ferr_f_q <= ferr_f_d;
            zero_q   <= zero_d;
            d_q      <= d_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            brk_q    <= brk_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = last ? '0 : cnt_q + CW'(1);
        idx_d    = idx_q;
        s0_d     = (cnt_q == C_S0) ? rxs : s0_q;
        s1_d     = (cnt_q == C_S1) ? rxs : s1_q;
        shift_d  = shift_q;
        par_d    = par_q;
        perr_f_d = perr_f_q;
        ferr_f_d = ferr_f_q;
        zero_d   = zero_q;
        complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d  = S_START;
                    idx_d    = '0;
                    par_d    = 1'b0;
                    perr_f_d = 1'b0;
                    ferr_f_d = 1'b0;
                    zero_d   = 1'b1;
                end
            end
            S_START: begin
                if (dec && maj) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (last) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                // LSB arrives first, so shifting in at the top leaves it at bit 0.
                if (dec) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ maj;
                    zero_d  = zero_q & ~maj;
                end
                if (last) begin
                    if (idx_q == I_DLAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (dec) begin
                    perr_f_d = (PARITY == 2) ? ~(par_q ^ maj) : (par_q ^ maj);
                    zero_d   = zero_q & ~maj;
                end
                if (last) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end
            end
            S_STOP: begin
                if (dec) begin
                    ferr_f_d = ferr_f_q | ~maj;
                    zero_d   = zero_q & ~maj;
                    if (idx_q == I_SLAST) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = (ferr_f_q | ~maj) ? S_WAIT_HIGH : S_IDLE;
                    end
                end else if (last) begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register: a completion is accepted only if the slot is free or drains this cycle.
    always_comb begin
        d_d     = d_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        ovr_d   = 1'b0;
        if (complete) begin
            if (!valid_q || ready_i) begin
                d_d     = shift_q;
                valid_d = 1'b1;
                perr_d  = perr_f_q;
                ferr_d  = ferr_f_q | ~maj;
                brk_d   = zero_q & ~maj;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign d_o          = d_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign break_o      = brk_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg at 16 clocks/bit: an 8E1 receiver with a scoreboard of
// expected frames, plus an 8O1 receiver on the same line for odd-parity checks.
module tb_uart_rx_cfg;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] d_o, o_d;
    logic       valid_o, parity_err_o, frame_err_o, break_o, overrun_o, busy_o;
    logic       o_valid, o_perr, o_ferr, o_brk, o_ovr, o_busy;

    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt = 0;
    int valid_cycles = 0;
    int odd_frames = 0;
    logic odd_perr = 1'b0;
    logic [10:0] exp_q[$];

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2)) u_even (
        .clk(clk), .resetn(resetn), .rx_i(rx_i), .d_o(d_o), .valid_o(valid_o), .ready_i(ready_i),
        .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .break_o(break_o),
        .overrun_o(overrun_o), .busy_o(busy_o));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_odd (
        .clk(clk), .resetn(resetn), .rx_i(rx_i), .d_o(o_d), .valid_o(o_valid), .ready_i(ready_i),
        .parity_err_o(o_perr), .frame_err_o(o_ferr), .break_o(o_brk),
        .overrun_o(o_ovr), .busy_o(o_busy));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: transfers are observed on the falling edge, away from the DUT's clock edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (overrun_o) ovr_cnt++;
            if (valid_o) valid_cycles++;
            if (valid_o && ready_i) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    check("frame", {21'd0, break_o, frame_err_o, parity_err_o, d_o}, {21'd0, e});
                end
            end
            if (o_valid && ready_i) begin
                odd_perr = o_perr;
                odd_frames++;
            end
        end
    end

    // Frame: start, 8 data LSB first, parity, stop. glitch_at inverts one clock of the frame.
    task automatic send_frame(input logic [7:0] data, input logic par_bit, input int glitch_at);
        for (int p = 0; p < 11; p++) begin
            logic b;
            if (p == 0) b = 1'b0;
            else if (p <= 8) b = data[p-1];
            else if (p == 9) b = par_bit;
            else b = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                rx_i = b ^ ((p * CPB + c) == glitch_at);
                @(negedge clk);
            end
        end
        rx_i = 1'b1;
    endtask

    task automatic push_even(input logic [7:0] data, input logic par_bit);
        exp_q.push_back({1'b0, 1'b0, (^data) ^ par_bit, data});
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ready_i = v;
    endtask

    initial begin
        int v0, f0, saw_busy;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_d", 32'(d_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_flags", {29'd0, parity_err_o, frame_err_o, break_o}, 0);
        check("rst_overrun", 32'(overrun_o), 0);

        // Clean back-to-back frames, even parity correct.
        push_even(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b0, -1);
        check("odd_perr_a5_p0", 32'(odd_perr), 1);
        push_even(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, -1);

        // Wrong parity for even mode, correct for odd mode.
        f0 = odd_frames;
        push_even(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, -1);
        check("odd_perr_a5_p1", 32'(odd_perr), 0);
        check("odd_frames", 32'(odd_frames - f0), 1);

        // Short low glitch on idle line is a false start.
        v0 = valid_cycles;
        saw_busy = 0;
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (busy_o) saw_busy = 1;
            @(negedge clk);
        end
        check("glitch_saw_busy", 32'(saw_busy), 1);
        check("glitch_busy_end", 32'(busy_o), 0);
        check("glitch_no_valid", 32'(valid_cycles - v0), 0);

        // One-clock inversion near the centre of data bit 3.
        push_even(8'h00, 1'b0);
        send_frame(8'h00, 1'b0, 4 * CPB + 9);
        repeat (4) @(negedge clk);

        // Line held low for 12 bit times: one break frame, then wait for the line to rise.
        exp_q.push_back({1'b1, 1'b1, 1'b0, 8'h00});
        v0 = valid_cycles;
        rx_i = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("break_busy_low", 32'(busy_o), 1);
        check("break_one_frame", 32'(valid_cycles - v0), 1);
        rx_i = 1'b1;
        repeat (6) @(negedge clk);
        check("break_busy_idle", 32'(busy_o), 0);
        push_even(8'h55, 1'b0);
        send_frame(8'h55, 1'b0, -1);
        check("no_overrun_yet", 32'(ovr_cnt), 0);

        // Consumer stalled: second frame is dropped with an overrun pulse.
        set_ready(1'b0);
        push_even(8'h11, 1'b0);
        send_frame(8'h11, 1'b0, -1);
        send_frame(8'h22, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("hold_valid", 32'(valid_o), 1);
        check("hold_d", 32'(d_o), 32'h11);
        check("overrun_pulses", 32'(ovr_cnt), 1);
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        check("drain_valid", 32'(valid_o), 0);

        // Reset in the middle of a frame: nothing emerges afterwards.
        v0 = valid_cycles;
        rx_i = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        resetn = 1'b0;
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_d", 32'(d_o), 0);
        check("mid_rst_valid", 32'(valid_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_flags", {28'd0, parity_err_o, frame_err_o, break_o, overrun_o}, 0);
        repeat (12 * CPB) @(negedge clk);
        check("mid_rst_no_valid", 32'(valid_cycles - v0), 0);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
